// File: rtl/stopwatch_control_pkg.sv
// Shared state encodings and default timing parameters for the stopwatch control path.
package stopwatch_control_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10
  } sw_state_e;

  localparam int unsigned TICK_DIV_DEFAULT        = 50000;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stopwatch_control_button_debouncer.sv
// Button front end: 2-flop synchronizer, stable-sample counter and a one-cycle press pulse.
module button_debouncer
  import stopwatch_control_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int unsigned     CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          db;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      db      <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
      press   <= 1'b0;
      if (sync_q2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // Accept the new level; only a rising acceptance counts as a press.
        db    <= sync_q2;
        cnt   <= '0;
        press <= sync_q2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_control.sv
// Stopwatch control: debounced buttons drive the IDLE/RUNNING/PAUSED FSM and the 1 ms prescaler.
module stopwatch_control
  import stopwatch_control_pkg::*;
#(
  parameter int unsigned TICK_DIV        = TICK_DIV_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_reset,
  output logic       st_signal,
  output logic       clear,
  output logic [1:0] state
);

  localparam int unsigned   PW         = cnt_width(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic          ss_press;
  logic          rst_press;
  sw_state_e     state_q;
  logic [PW-1:0] presc;
  logic          presc_wrap;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start_stop (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_start_stop),
    .press (ss_press)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_reset (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_reset),
    .press (rst_press)
  );

  assign presc_wrap = (presc == PRESC_LAST);
  assign state      = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      presc     <= '0;
      st_signal <= 1'b0;
      clear     <= 1'b0;
    end else begin
      clear     <= rst_press;
      st_signal <= 1'b0;
      if (rst_press) begin
        state_q <= ST_IDLE;
        presc   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            presc <= '0;
            if (ss_press) state_q <= ST_RUNNING;
          end
          ST_RUNNING: begin
            // The pausing edge still counts; its tick is dropped so no pulse lands in PAUSED.
            presc <= presc_wrap ? '0 : presc + PW'(1);
            if (ss_press) state_q <= ST_PAUSED;
            else          st_signal <= presc_wrap;
          end
          ST_PAUSED: begin
            if (ss_press) state_q <= ST_RUNNING;
          end
          default: begin
            state_q <= ST_IDLE;
            presc   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_control.sv
// Scoreboard bench for stopwatch_control with TICK_DIV=10, DEBOUNCE_CYCLES=4.
`timescale 1ns/1ps
module tb_stopwatch_control;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_start_stop;
  logic       btn_reset;
  logic       st_signal;
  logic       clear;
  logic [1:0] state;

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;
  logic [1:0]  prev_state = 2'b00;

  typedef struct {
    int unsigned cyc;
    logic        st;
    logic        clr;
    logic [1:0]  state;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  stopwatch_control #(.TICK_DIV(10), .DEBOUNCE_CYCLES(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .btn_start_stop (btn_start_stop),
    .btn_reset      (btn_reset),
    .st_signal      (st_signal),
    .clear          (clear),
    .state          (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int unsigned c, input logic s, input logic cl,
                      input logic [1:0] stv, input string nm);
    exp_t e;
    e.cyc = c; e.st = s; e.clr = cl; e.state = stv; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [1:0] got, input logic [1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%b want=%b", nm, got, want);
    end
  endtask

  task automatic wait_to(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: any pulse or state change is an output event matched against the queue head.
  always @(negedge clk) begin
    if (st_signal || clear || (state != prev_state)) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event cyc=%0d st=%b clr=%b state=%b",
                 cyc, st_signal, clear, state);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.st !== st_signal || e.clr !== clear || e.state !== state) begin
          failures++;
          $display("FAIL %s got cyc=%0d st=%b clr=%b state=%b want cyc=%0d st=%b clr=%b state=%b",
                   e.name, cyc, st_signal, clear, state, e.cyc, e.st, e.clr, e.state);
        end
      end
    end
    prev_state <= state;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d pending=%0d", cyc, exp_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned p, r, s, t;
    reset = 1'b0; btn_start_stop = 1'b0; btn_reset = 1'b0;
    #12;
    chk("reset_st", {1'b0, st_signal}, 2'b00);
    chk("reset_clr", {1'b0, clear}, 2'b00);
    chk("reset_state", state, 2'b00);
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);

    // Async reset dropped mid-cycle while RUNNING, before the first tick.
    p = cyc;
    push(p + 7, 1'b0, 1'b0, 2'b01, "t1_run");
    btn_start_stop = 1'b1;
    wait_to(p + 8);  btn_start_stop = 1'b0;
    wait_to(p + 10);
    @(posedge clk); #2;
    push(cyc, 1'b0, 1'b0, 2'b00, "t1_async_event");
    reset = 1'b0;
    #1;
    chk("t1_async_st", {1'b0, st_signal}, 2'b00);
    chk("t1_async_clr", {1'b0, clear}, 2'b00);
    chk("t1_async_state", state, 2'b00);
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);

    // Bouncy start: 1,0,1,0 two-cycle pulses then held -> one IDLE->RUNNING; 10 ticks; reset press.
    p = cyc;
    r = p + 15;
    push(r, 1'b0, 1'b0, 2'b01, "t2_run");
    for (int k = 1; k <= 10; k++) push(r + 10 * k, 1'b1, 1'b0, 2'b01, "t3_tick");
    push(r + 110, 1'b0, 1'b1, 2'b00, "t5_clear");
    btn_start_stop = 1'b1;
    wait_to(p + 2);  btn_start_stop = 1'b0;
    wait_to(p + 4);  btn_start_stop = 1'b1;
    wait_to(p + 6);  btn_start_stop = 1'b0;
    wait_to(p + 8);  btn_start_stop = 1'b1;
    wait_to(r + 2);  btn_start_stop = 1'b0;
    wait_to(r + 5);  btn_start_stop = 1'b1;
    wait_to(r + 10); btn_reset = 1'b1;
    wait_to(r + 13); btn_reset = 1'b0;
    wait_to(r + 20); btn_start_stop = 1'b0;
    wait_to(r + 103); btn_reset = 1'b1;
    wait_to(r + 115); btn_reset = 1'b0;

    // Restart, pause after 37 cycles (prescaler 7), idle, resume, pause again, both buttons.
    wait_to(r + 120);
    s = cyc;
    push(s + 7, 1'b0, 1'b0, 2'b01, "t5_restart");
    push(s + 17, 1'b1, 1'b0, 2'b01, "t5_first_tick");
    push(s + 27, 1'b1, 1'b0, 2'b01, "t4_tick2");
    push(s + 37, 1'b1, 1'b0, 2'b01, "t4_tick3");
    push(s + 44, 1'b0, 1'b0, 2'b10, "t4_pause");
    push(s + 101, 1'b0, 1'b0, 2'b01, "t4_resume");
    push(s + 104, 1'b1, 1'b0, 2'b01, "t4_partial_tick");
    push(s + 114, 1'b1, 1'b0, 2'b01, "t4_full_tick");
    push(s + 122, 1'b0, 1'b0, 2'b10, "t6_pause");
    push(s + 142, 1'b0, 1'b1, 2'b00, "t6_both");
    btn_start_stop = 1'b1;
    wait_to(s + 10);  btn_start_stop = 1'b0;
    wait_to(s + 37);  btn_start_stop = 1'b1;
    wait_to(s + 45);  btn_start_stop = 1'b0;
    wait_to(s + 94);  btn_start_stop = 1'b1;
    wait_to(s + 102); btn_start_stop = 1'b0;
    wait_to(s + 115); btn_start_stop = 1'b1;
    wait_to(s + 123); btn_start_stop = 1'b0;
    wait_to(s + 135); btn_start_stop = 1'b1; btn_reset = 1'b1;
    wait_to(s + 145); btn_reset = 1'b0;
    wait_to(s + 1135); btn_start_stop = 1'b0;

    // Fresh press held 1000 cycles -> a single toggle, then stop with a reset press.
    wait_to(s + 1150);
    t = cyc;
    push(t + 7, 1'b0, 1'b0, 2'b01, "t6_single_toggle");
    for (int k = 1; k <= 100; k++) push(t + 7 + 10 * k, 1'b1, 1'b0, 2'b01, "t6_tick");
    push(t + 1010, 1'b0, 1'b1, 2'b00, "t6_final_clear");
    btn_start_stop = 1'b1;
    wait_to(t + 1000); btn_start_stop = 1'b0;
    wait_to(t + 1003); btn_reset = 1'b1;
    wait_to(t + 1013); btn_reset = 1'b0;

    wait_to(t + 1040);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events got=%0d pending want=0 next=%s at cyc=%0d",
               exp_q.size(), exp_q[0].name, exp_q[0].cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
